mat_mul_result_collector: RTL and testbench
===========================================

Name: mat_mul_result_collector

Overview:
- Sits directly downstream of the 4x4 complex matrix multiplier.
- Captures the multiplier's serial complex output stream (one Q7.11 element per valid cycle, row-major) into an internal 4x4 buffer.
- Flags when a full matrix is available and gives the consumer (MMSE/inverse stage) random-access reads.
- Back-pressures the start of the next multiplication until the consumer releases the buffer.

Parameters:
- DATA_WIDTH, 18, bits per real/imag component (Q7.11 two's complement)
- MAT_DIM, 4, matrix dimension; element count N_ELEM = MAT_DIM*MAT_DIM; ADDR_W = clog2(N_ELEM)

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  element strobe from multiplier (valid)
- in_done  in  1  last-element marker from multiplier (done)
- in_r  in  DATA_WIDTH  serial element real part
- in_i  in  DATA_WIDTH  serial element imag part
- mul_start_allow  out  1  high when the buffer can accept a new frame; gates multiplier Start_Mul
- mat_ready  out  1  full matrix held in buffer
- mat_ack  in  1  one-cycle pulse from consumer releasing the buffer
- rd_addr  in  ADDR_W  row-major element index (row*MAT_DIM+col)
- rd_data_r  out  DATA_WIDTH  registered read, real
- rd_data_i  out  DATA_WIDTH  registered read, imag
- frame_cnt  out  8  completed-frame counter

Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Reset values:
  - State IDLE; write count 0.
  - mat_ready=0, mul_start_allow=1, rd_data_r/i=0, frame_cnt=0.
  - Buffer contents are not cleared.
- Storage: 2*N_ELEM registers of DATA_WIDTH. Values are stored unmodified; no arithmetic on data.
- FSM states:
  - IDLE:
    - in_valid: write buf[0], cnt=1, go FILL.
    - mul_start_allow=1.
  - FILL:
    - Each in_valid: write buf[cnt], cnt++.
    - On the write with cnt==N_ELEM-1: go FULL, cnt=0.
    - mul_start_allow=0 from the cycle after entering FILL.
  - FULL:
    - mat_ready=1 (asserted the cycle after the last write), mul_start_allow=0.
    - in_valid is dropped; buffer is not overwritten.
    - mat_ack: go IDLE; mat_ready=0 and mul_start_allow=1 next cycle.
- Simultaneous mat_ack and in_valid in FULL: the element is accepted as element 0 of a new frame (write buf[0], cnt=1, go FILL); mat_ready deasserts.
- mat_ack outside FULL: ignored.
- in_done is not used for control without the optional feature; completion is count-based.
- frame_cnt: increments by 1 on each FILL->FULL transition; wraps 255->0.
- Read port:
  - rd_data_r/i = buf[rd_addr] registered, 1-cycle latency, in any state.
  - A read of an address written in the same cycle returns the old value.
  - rd_addr >= N_ELEM (only possible for non-power-of-2 N_ELEM) returns 0.
- Reset mid-FILL: partial frame abandoned; state IDLE, cnt 0; next in_valid starts at buf[0].

Optional Feature:
- Macro: MAT_COLLECT_ERR_CHECK_EN.
- With the macro defined, extra output frame_err (1 bit, reset 0, sticky until rst or mat_ack):
  - Set if in_done arrives with in_valid while cnt != N_ELEM-1 (short frame). In that case go IDLE, discard the partial frame; frame_cnt is unchanged.
  - Set if in_valid arrives in FULL without same-cycle mat_ack (overrun).
- Without the macro: no frame_err port; in_done is ignored; overrun is silently dropped.

Test Plan:
- Nominal frame:
  - Stimulus: rst 2 cycles; 16 consecutive in_valid with in_r=k, in_i=0x3FFFF-k (k=0..15), in_done on k=15.
  - Required: mat_ready=1 one cycle after the 16th write; mul_start_allow=0; frame_cnt=1; rd_addr=5 gives rd_data_r=5, rd_data_i=0x3FFFA next cycle.
- Gapped input:
  - Stimulus: 16 elements with in_valid deasserted for 3 cycles between each.
  - Required: identical buffer contents; mat_ready only after the 16th element.
- Overrun:
  - Stimulus: in FULL, drive in_valid with in_r=0x12345 without ack.
  - Required: buf[0] unchanged; mat_ready stays 1; frame_err=1 if MAT_COLLECT_ERR_CHECK_EN is defined.
- Ack with same-cycle element:
  - Stimulus: mat_ack and in_valid (in_r=0x00046) in the same cycle.
  - Required: mat_ready=0 next cycle; buf[0]=0x00046; state FILL with cnt=1.
- Reset mid-frame:
  - Stimulus: rst after 7 elements, then a full 16-element frame.
  - Required: frame_cnt=1; all 16 addresses hold the new-frame values.
- Wrap and short frame:
  - Stimulus: 256 frames, each acked.
  - Required: frame_cnt wraps to 0.
  - With MAT_COLLECT_ERR_CHECK_EN: in_done on element 9 sets frame_err=1, state IDLE, frame_cnt unchanged.

Source files
------------

// File: rtl/mat_mul_result_collector.sv
// Result collector behind the 4x4 complex matrix multiplier.
// Captures the row-major serial output stream into a 4x4 buffer and
// holds it for random-access reads until the consumer releases it.
//
// Ports:
//   clk             : single clock, all logic on the rising edge
//   rst             : synchronous active-high reset
//   in_valid        : element strobe from the multiplier
//   in_done         : last-element marker from the multiplier
//   in_r / in_i     : serial element, real / imag (Q7.11)
//   mul_start_allow : buffer can take a new frame (gates Start_Mul)
//   mat_ready       : a full matrix is held in the buffer
//   mat_ack         : one-cycle release pulse from the consumer
//   rd_addr         : row-major element index (row*MAT_DIM+col)
//   rd_data_r/_i    : registered read data, 1-cycle latency
//   frame_cnt       : completed-frame counter, wraps at 256
//   frame_err       : sticky short-frame / overrun flag
//                     (only with MAT_COLLECT_ERR_CHECK_EN defined)
//
// Build option: define MAT_COLLECT_ERR_CHECK_EN to enable in_done
// checking and the frame_err output. Without it, in_done is ignored,
// completion is count-based and overruns are silently dropped.

module mat_mul_result_collector #(
  parameter  int DATA_WIDTH = 18,
  parameter  int MAT_DIM    = 4,
  localparam int N_ELEM     = MAT_DIM * MAT_DIM,
  localparam int ADDR_W     = (N_ELEM > 1) ? $clog2(N_ELEM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_done,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  output logic                  mul_start_allow,
  output logic                  mat_ready,
  input  logic                  mat_ack,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data_r,
  output logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [7:0]            frame_cnt
`ifdef MAT_COLLECT_ERR_CHECK_EN
  ,
  output logic                  frame_err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(N_ELEM - 1);
  localparam logic [ADDR_W:0] N_LIM =
    (ADDR_W + 1)'(N_ELEM);

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;
  logic [7:0]        fcnt_q;
  logic [7:0]        fcnt_d;

  logic [DATA_WIDTH-1:0] mem_r_q [N_ELEM];
  logic [DATA_WIDTH-1:0] mem_i_q [N_ELEM];
  logic [DATA_WIDTH-1:0] rd_r_q;
  logic [DATA_WIDTH-1:0] rd_i_q;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              accept;
  logic              short_frame;
  logic [ADDR_W-1:0] idx;
  logic              ack_full;

  // Index the incoming element lands on: a frame started from IDLE,
  // or from FULL on the same cycle as the ack, always begins at 0.
  assign idx = (state_q == FILL) ? cnt_q : '0;

  assign ack_full = (state_q == FULL) && mat_ack;

  // An element is taken unless the buffer is held and not released.
  assign accept = in_valid &&
                  ((state_q != FULL) || mat_ack);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    we      = 1'b0;
    waddr   = idx;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
      end
      FILL: begin
        cnt_d = cnt_q;
      end
      FULL: begin
        if (mat_ack) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (accept) begin
      if (short_frame) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        we = 1'b1;
        if (idx == LAST) begin
          state_d = FULL;
          cnt_d   = '0;
          fcnt_d  = fcnt_q + 8'd1;
        end else begin
          state_d = FILL;
          cnt_d   = idx + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Frame storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r_q[waddr] <= in_r;
      mem_i_q[waddr] <= in_i;
    end
  end

  // Registered read; a same-cycle write is seen one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_r_q <= '0;
      rd_i_q <= '0;
    end else if ({1'b0, rd_addr} < N_LIM) begin
      rd_r_q <= mem_r_q[rd_addr];
      rd_i_q <= mem_i_q[rd_addr];
    end else begin
      rd_r_q <= '0;
      rd_i_q <= '0;
    end
  end

`ifdef MAT_COLLECT_ERR_CHECK_EN
  logic err_q;
  logic err_d;

  assign short_frame = in_done && (idx != LAST);

  // Setting wins over the ack clear so an error on the
  // restarting element is not lost.
  always_comb begin
    err_d = err_q;
    if (ack_full) begin
      err_d = 1'b0;
    end
    if (in_valid && (state_q == FULL) && !mat_ack) begin
      err_d = 1'b1;
    end
    if (accept && short_frame) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign frame_err = err_q;
`else
  logic unused_ctl;

  assign short_frame = 1'b0;
  assign unused_ctl  = in_done ^ ack_full;
`endif

  assign mul_start_allow = (state_q == IDLE);
  assign mat_ready       = (state_q == FULL);
  assign rd_data_r       = rd_r_q;
  assign rd_data_i       = rd_i_q;
  assign frame_cnt       = fcnt_q;

endmodule

// File: tb/tb_mat_mul_result_collector.sv
// Self-checking bench for mat_mul_result_collector.
// Frame-level queue model plus directed literal checks.

module tb_mat_mul_result_collector;

  localparam int DW = 18;
  localparam int N  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_done;
  logic [DW-1:0] in_r;
  logic [DW-1:0] in_i;
  logic          mul_start_allow;
  logic          mat_ready;
  logic          mat_ack;
  logic [3:0]    rd_addr;
  logic [DW-1:0] rd_data_r;
  logic [DW-1:0] rd_data_i;
  logic [7:0]    frame_cnt;
`ifdef MAT_COLLECT_ERR_CHECK_EN
  logic          frame_err;
`endif

  mat_mul_result_collector #(
    .DATA_WIDTH(DW),
    .MAT_DIM(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_done(in_done),
    .in_r(in_r),
    .in_i(in_i),
    .mul_start_allow(mul_start_allow),
    .mat_ready(mat_ready),
    .mat_ack(mat_ack),
    .rd_addr(rd_addr),
    .rd_data_r(rd_data_r),
    .rd_data_i(rd_data_i),
    .frame_cnt(frame_cnt)
`ifdef MAT_COLLECT_ERR_CHECK_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(string name,
                       logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               name, got, exp);
    end
  endtask

  // Behavioural model: elements collected so far in the current
  // frame, whether a full matrix is held, and buffer contents.
  int            m_pend;
  bit            m_full;
  int            m_fcnt;
  bit            m_err;
  logic [DW-1:0] mb_r [N];
  logic [DW-1:0] mb_i [N];
  bit            mdef [N];
  logic [DW-1:0] m_rd_r;
  logic [DW-1:0] m_rd_i;
  bit            m_rd_known;
  bit            armed = 1'b0;

  initial begin
    for (int k = 0; k < N; k++) begin
      mb_r[k] = '0;
      mb_i[k] = '0;
      mdef[k] = 1'b0;
    end
  end

  function automatic void m_take();
    bit shrt;
    shrt = 1'b0;
`ifdef MAT_COLLECT_ERR_CHECK_EN
    shrt = in_done && (m_pend != N - 1);
`endif
    if (shrt) begin
      m_err  = 1'b1;
      m_pend = 0;
    end else begin
      mb_r[m_pend] = in_r;
      mb_i[m_pend] = in_i;
      mdef[m_pend] = 1'b1;
      m_pend++;
      if (m_pend == N) begin
        m_full = 1'b1;
        m_pend = 0;
        m_fcnt = (m_fcnt + 1) % 256;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pend     = 0;
      m_full     = 1'b0;
      m_fcnt     = 0;
      m_err      = 1'b0;
      m_rd_r     = '0;
      m_rd_i     = '0;
      m_rd_known = 1'b1;
      armed      = 1'b1;
    end else begin
      m_rd_r     = mb_r[rd_addr];
      m_rd_i     = mb_i[rd_addr];
      m_rd_known = mdef[rd_addr];
      if (m_full) begin
        if (mat_ack) begin
          m_full = 1'b0;
          m_err  = 1'b0;
          if (in_valid) m_take();
        end else if (in_valid) begin
          m_err = 1'b1;
        end
      end else if (in_valid) begin
        m_take();
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("ready", mat_ready, m_full);
      check("allow", mul_start_allow,
            !m_full && m_pend == 0);
      check("fcnt", frame_cnt, m_fcnt[7:0]);
      if (m_rd_known) begin
        check("rd_r", rd_data_r, m_rd_r);
        check("rd_i", rd_data_i, m_rd_i);
      end
`ifdef MAT_COLLECT_ERR_CHECK_EN
      check("err", frame_err, m_err);
`endif
    end
  end

  task automatic cyc(bit v, bit d,
                     logic [DW-1:0] r,
                     logic [DW-1:0] i,
                     bit a, logic [3:0] ad);
    in_valid = v;
    in_done  = d;
    in_r     = r;
    in_i     = i;
    mat_ack  = a;
    rd_addr  = ad;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n, logic [3:0] ad);
    repeat (n) cyc(0, 0, '0, '0, 0, ad);
  endtask

  function automatic logic [DW-1:0] vr(int v);
    return DW'(v);
  endfunction

  function automatic logic [DW-1:0] vi(int v);
    return 18'h3FFFF - DW'(v);
  endfunction

  task automatic send_frame(int base, int gap);
    for (int k = 0; k < N; k++) begin
      cyc(1, k == N - 1, vr(base + k),
          vi(base + k), 0, 4'(k));
      if (k != N - 1) idle(gap, 4'(k));
    end
  endtask

  task automatic read_all(int base);
    for (int a = 0; a < N; a++) begin
      idle(1, 4'(a));
      check("rdall_r", rd_data_r, vr(base + a));
      check("rdall_i", rd_data_i, vi(base + a));
    end
  endtask

  initial begin
    rst = 1'b1;
    idle(2, 4'd0);
    check("rst_ready", mat_ready, 0);
    check("rst_allow", mul_start_allow, 1);
    check("rst_fcnt", frame_cnt, 0);
    check("rst_rd", rd_data_r, 0);
    rst = 1'b0;

    // Nominal frame
    send_frame(0, 0);
    check("nom_ready", mat_ready, 1);
    check("nom_allow", mul_start_allow, 0);
    check("nom_fcnt", frame_cnt, 1);
    check("nom_model_full", m_full, 1);
    idle(1, 4'd5);
    check("nom_rd5_r", rd_data_r, 18'h00005);
    check("nom_rd5_i", rd_data_i, 18'h3FFFA);

    // Overrun while held
    cyc(1, 0, 18'h12345, '0, 0, 4'd0);
    check("ovr_ready", mat_ready, 1);
    idle(1, 4'd0);
    check("ovr_buf0", rd_data_r, 0);
`ifdef MAT_COLLECT_ERR_CHECK_EN
    check("ovr_err", frame_err, 1);
`endif

    // Ack with same-cycle element 0
    cyc(1, 0, 18'h00046, vi(0), 1, 4'd0);
    check("ackv_ready", mat_ready, 0);
    check("ackv_allow", mul_start_allow, 0);
    idle(1, 4'd0);
    check("ackv_buf0", rd_data_r, 18'h00046);
    for (int k = 1; k < N; k++)
      cyc(1, k == N - 1, vr(k), vi(k), 0, 4'd0);
    check("ackv_ready2", mat_ready, 1);
    check("ackv_fcnt", frame_cnt, 2);
`ifdef MAT_COLLECT_ERR_CHECK_EN
    check("ackv_err", frame_err, 0);
`endif

    // Gapped input
    cyc(0, 0, '0, '0, 1, 4'd0);
    for (int k = 0; k < N - 1; k++) begin
      cyc(1, 0, vr(k), vi(k), 0, 4'd0);
      idle(3, 4'd0);
    end
    check("gap_notready", mat_ready, 0);
    cyc(1, 1, vr(N - 1), vi(N - 1), 0, 4'd0);
    check("gap_ready", mat_ready, 1);
    check("gap_fcnt", frame_cnt, 3);
    read_all(0);

    // Reset mid-frame
    cyc(0, 0, '0, '0, 1, 4'd0);
    for (int k = 0; k < 7; k++)
      cyc(1, 0, vr(512 + k), vi(512 + k), 0, 4'd0);
    rst = 1'b1;
    idle(1, 4'd0);
    rst = 1'b0;
    check("rmid_allow", mul_start_allow, 1);
    send_frame(256, 0);
    check("rmid_fcnt", frame_cnt, 1);
    read_all(256);

    // Randomized traffic, model-checked every cycle
    cyc(0, 0, '0, '0, 1, 4'd0);
    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 9) < 7,
          $urandom_range(0, 19) == 0,
          DW'($urandom), DW'($urandom),
          $urandom_range(0, 11) == 0,
          4'($urandom_range(0, 15)));
    end

    // Counter wrap over 256 frames
    rst = 1'b1;
    idle(1, 4'd0);
    rst = 1'b0;
    for (int f = 0; f < 256; f++) begin
      send_frame(f, 0);
      if (f == 254) check("wrap_255", frame_cnt, 255);
      cyc(0, 0, '0, '0, 1, 4'd0);
    end
    check("wrap_0", frame_cnt, 0);
    check("wrap_model", m_fcnt, 0);

`ifdef MAT_COLLECT_ERR_CHECK_EN
    // Short frame: done on element 9
    for (int k = 0; k < 10; k++)
      cyc(1, k == 9, vr(k), vi(k), 0, 4'd0);
    check("short_err", frame_err, 1);
    check("short_allow", mul_start_allow, 1);
    check("short_ready", mat_ready, 0);
    check("short_fcnt", frame_cnt, 0);
`endif

    idle(2, 4'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
